// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin arbiter sharing one combinational ALU between two requesters,
// holding registered ALU inputs for SETTLE cycles and returning result/carry over valid/ready.
module alu_op_scheduler #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [5:0]         req_cmd,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_cmd,
    output logic               alu_carryin,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryout,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;
    state_t     state;
    logic       ptr;
    logic       owner;
    logic       grant;
    logic [3:0] cnt;
    logic [2:0] grant_cmd;
    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign grant     = req_valid[1] & (~req_valid[0] | ptr);
    assign grant_cmd = grant ? req_cmd[5:3] : req_cmd[2:0];
    assign req_ready = (rst_n && state == S_IDLE) ? {req_valid[1] & grant, req_valid[0] & ~grant} : 2'b00;
    assign busy      = state != S_IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            cnt         <= 4'd0;
            rsp_valid   <= 2'b00;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cmd     <= 3'b000;
            alu_carryin <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (|req_valid) begin
                    alu_a       <= grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    alu_b       <= grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    alu_cmd     <= grant_cmd;
                    alu_carryin <= grant_cmd == 3'b001;
                    owner       <= grant;
                    ptr         <= ~grant;
                    cnt         <= SETTLE[3:0];
                    state       <= S_SETTLE;
                end
                S_SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_result <= alu_result;
                        rsp_carry  <= alu_carryout & (alu_cmd[2:1] == 2'b00);
                        rsp_valid  <= owner ? 2'b10 : 2'b01;
                        state      <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready[owner]) begin
                    rsp_valid <= 2'b00;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: directed tests of arbitration, settle timing, response hold and async abort.
module tb_alu_op_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
    logic [63:0] req_a = '0, req_b = '0;
    logic [5:0]  req_cmd = '0;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]  alu_cmd;
    logic        rsp_carry, alu_carryin, alu_carryout, busy;

    logic [1:0]  r_valid = '0, r_ready, r_rsp_valid, r_rsp_ready = 2'b11;
    logic [63:0] r_a = '0, r_b = '0;
    logic [5:0]  r_cmd = '0;
    logic [31:0] r_result, r_alu_a, r_alu_b, r_alu_res;
    logic [2:0]  r_alu_cmd;
    logic        r_carry, r_cin, r_alu_co, r_busy;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] c, logic ci);
        logic [32:0] s;
        logic [31:0] r;
        s = {1'b0, a} + {1'b0, (c == 3'd1) ? ~b : b} + {32'd0, ci};
        case (c)
            3'd0, 3'd1: r = s[31:0];
            3'd2: r = a ^ b;
            3'd3: r = {31'd0, $signed(a) < $signed(b)};
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {s[32], r};
    endfunction

    assign {alu_carryout, alu_result} = alu_f(alu_a, alu_b, alu_cmd, alu_carryin);
    assign {r_alu_co, r_alu_res}      = alu_f(r_alu_a, r_alu_b, r_alu_cmd, r_cin);

    alu_op_scheduler #(.WIDTH(32), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_carryin(alu_carryin),
        .alu_result(alu_result), .alu_carryout(alu_carryout), .busy(busy));

    alu_op_scheduler #(.WIDTH(32), .SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(r_valid), .req_ready(r_ready),
        .req_a(r_a), .req_b(r_b), .req_cmd(r_cmd), .rsp_valid(r_rsp_valid),
        .rsp_ready(r_rsp_ready), .rsp_result(r_result), .rsp_carry(r_carry),
        .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_cmd(r_alu_cmd), .alu_carryin(r_cin),
        .alu_result(r_alu_res), .alu_carryout(r_alu_co), .busy(r_busy));

    task automatic test_reset();
        #2;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({alu_a, alu_b, alu_cmd, alu_carryin, rsp_result, rsp_carry} !== '0) begin
            failures++; $display("FAIL reset_regs got a=%h b=%h cmd=%b cin=%b res=%h c=%b exp all zero",
                alu_a, alu_b, alu_cmd, alu_carryin, rsp_result, rsp_carry); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add_boundary();
        @(posedge clk); #1;
        req_a[31:0] = 32'hFFFF_FFFF; req_b[31:0] = 32'h1; req_cmd[2:0] = 3'b000; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_req_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1 || alu_a !== 32'hFFFF_FFFF || alu_carryin !== 1'b0) begin
            failures++; $display("FAIL add_settle got v=%b busy=%b a=%h cin=%b exp v=00 busy=1 a=ffffffff cin=0",
                rsp_valid, busy, alu_a, alu_carryin); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0 || rsp_carry !== 1'b1) begin
            failures++; $display("FAIL add_rsp got v=%b res=%h c=%b exp v=01 res=00000000 c=1", rsp_valid, rsp_result, rsp_carry); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL add_done got busy=%b v=%b exp busy=0 v=00", busy, rsp_valid); end
    endtask

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic [31:0] exp_r, input logic exp_c);
        logic [1:0] oh;
        int n;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        if (idx == 1) begin req_a[63:32] = a; req_b[63:32] = b; req_cmd[5:3] = c; end
        else begin req_a[31:0] = a; req_b[31:0] = b; req_cmd[2:0] = c; end
        req_valid = oh;
        #1;
        checks++; if (req_ready !== oh) begin failures++; $display("FAIL op_req_ready got=%b exp=%b", req_ready, oh); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (alu_carryin !== (c == 3'b001)) begin failures++; $display("FAIL op_carryin got=%b exp=%b", alu_carryin, c == 3'b001); end
        n = 0;
        while (rsp_valid === 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (rsp_valid !== oh || rsp_result !== exp_r || rsp_carry !== exp_c) begin
            failures++; $display("FAIL op_rsp got v=%b res=%h c=%b exp v=%b res=%h c=%b", rsp_valid, rsp_result, rsp_carry, oh, exp_r, exp_c); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL op_handshake got v=%b exp=00", rsp_valid); end
    endtask

    task automatic test_sub();
        do_op(1, 32'd5, 32'd3, 3'b001, 32'h0000_0002, 1'b1);
        do_op(1, 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        int n;
        @(posedge clk); #1;
        req_a = {32'h0000_FF00, 32'd10}; req_b = {32'h0000_0FF0, 32'd20}; req_cmd = {3'b010, 3'b000};
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = k[0] ? 2'b10 : 2'b01;
            n = 0;
            while (req_ready === 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
            checks++; if (req_ready !== exp) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp); end
            @(posedge clk); #1;
            if (k == 3) req_valid = 2'b00;
            n = 0;
            while (rsp_valid === 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
            checks++; if (rsp_valid !== exp || rsp_result !== (k[0] ? 32'h0000_F0F0 : 32'd30)) begin
                failures++; $display("FAIL rr_rsp%0d got v=%b res=%h exp v=%b res=%h", k, rsp_valid, rsp_result, exp,
                    k[0] ? 32'h0000_F0F0 : 32'd30); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        int n;
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        req_a = {32'd1, 32'hF0F0_F0F0}; req_b = {32'd2, 32'hFF00_FF00}; req_cmd = {3'b000, 3'b100};
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL hold_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        n = 0;
        while (rsp_valid === 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'hF000_F000 || rsp_carry !== 1'b0 || req_ready !== 2'b00) begin
                failures++; $display("FAIL hold_wait%0d got v=%b res=%h c=%b rdy=%b exp v=01 res=f000f000 c=0 rdy=00",
                    k, rsp_valid, rsp_result, rsp_carry, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            failures++; $display("FAIL hold_release got v=%b rdy=%b exp v=00 rdy=10", rsp_valid, req_ready); end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_async_abort();
        @(posedge clk); #1;
        r_a[31:0] = 32'd1; r_b[31:0] = 32'd2; r_cmd[2:0] = 3'b000; r_valid = 2'b01;
        @(posedge clk); #1;
        r_a[63:32] = 32'd7; r_b[63:32] = 32'd8; r_cmd[5:3] = 3'b000; r_valid = 2'b10;
        checks++; if (r_busy !== 1'b1 || r_alu_a !== 32'd1) begin
            failures++; $display("FAIL abort_accept got busy=%b a=%h exp busy=1 a=00000001", r_busy, r_alu_a); end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (r_busy !== 1'b0 || r_ready !== 2'b00 || r_rsp_valid !== 2'b00 ||
                      {r_alu_a, r_alu_b, r_alu_cmd, r_cin, r_result, r_carry} !== '0) begin
            failures++; $display("FAIL abort_reset got busy=%b rdy=%b v=%b a=%h b=%h cmd=%b cin=%b res=%h c=%b exp all zero",
                r_busy, r_ready, r_rsp_valid, r_alu_a, r_alu_b, r_alu_cmd, r_cin, r_result, r_carry); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (r_rsp_valid !== 2'b00) begin failures++; $display("FAIL abort_no_rsp got v=%b exp=00", r_rsp_valid); end
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (r_ready !== 2'b10) begin failures++; $display("FAIL abort_regrant got=%b exp=10", r_ready); end
        @(posedge clk); #1;
        r_valid = 2'b00;
        checks++; if (r_alu_a !== 32'd7 || r_alu_b !== 32'd8) begin
            failures++; $display("FAIL abort_load got a=%h b=%h exp a=00000007 b=00000008", r_alu_a, r_alu_b); end
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            checks++; if (r_rsp_valid !== 2'b00) begin failures++; $display("FAIL settle4_early%0d got v=%b exp=00", k, r_rsp_valid); end
        end
        @(posedge clk); #1;
        checks++; if (r_rsp_valid !== 2'b10 || r_result !== 32'd15 || r_carry !== 1'b0) begin
            failures++; $display("FAIL settle4_rsp got v=%b res=%h c=%b exp v=10 res=0000000f c=0", r_rsp_valid, r_result, r_carry); end
        @(posedge clk); #1;
        checks++; if (r_rsp_valid !== 2'b00 || r_busy !== 1'b0) begin
            failures++; $display("FAIL settle4_done got v=%b busy=%b exp v=00 busy=0", r_rsp_valid, r_busy); end
    endtask

    initial begin
        test_reset();
        test_add_boundary();
        test_sub();
        test_round_robin();
        test_hold();
        test_async_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Two-requester scheduler that shares one combinational 32-bit ALU between two independent clients. It arbitrates round-robin, drives the ALU's operand/command/carry-in inputs from registers, and holds them stable for a programmable settle time. It then captures the ALU result and carry and returns them to the winning requester over a valid/ready response handshake. It sits between the instruction-side sequencers and the shared ALU datapath; the ALU itself is instantiated outside this block.

## Interface
- WIDTH, 32, operand/result width
- SETTLE, 1, cycles ALU inputs are held before capture; legal range 1..15
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  bit i = requester i has an operation
- req_ready  out  2  bit i = requester i accepted this cycle
- req_a, req_b  in  2*WIDTH  requester i operands at [i*WIDTH +: WIDTH]
- req_cmd  in  6  requester i command at [i*3 +: 3]: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
- rsp_valid  out  2  bit i = response for requester i pending
- rsp_ready  in  2  bit i = requester i takes response
- rsp_result  out  WIDTH  captured ALU result
- rsp_carry  out  1  captured carry; 0 for any command other than ADD/SUB
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_cmd  out  3  registered ALU command
- alu_carryin  out  1  1 for SUB, else 0
- alu_result  in  WIDTH  ALU result
- alu_carryout  in  1  ALU carry-out
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SETTLE, RESP. Reset enters IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_carry=0, alu_a=alu_b=0, alu_cmd=000, alu_carryin=0, busy=0, round-robin pointer=0, owner=0.
- IDLE, grant selection:
  - If exactly one req_valid bit is set, that requester is granted.
  - If both are set, the requester equal to the pointer is granted.
- IDLE, accept:
  - req_ready[g] is asserted combinationally, only in IDLE, only for the granted requester.
  - On accept: load alu_a/alu_b/alu_cmd from requester g and set alu_carryin = (cmd==001).
  - Also set owner=g, settle counter=SETTLE, pointer=~g, then go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture alu_result into rsp_result and the carry into rsp_carry (alu_carryout when cmd is ADD/SUB, else 0).
  - Then set rsp_valid[owner]=1 and go to RESP.
- RESP:
  - Hold rsp_valid[owner] and the response data stable until rsp_ready[owner]=1.
  - On that edge, clear rsp_valid and go to IDLE.
  - rsp_ready of the non-owner is ignored.
- ALU drive registers change only on accept. They hold their last value through RESP and IDLE.
- Operands are passed unmodified; SUB inversion is the ALU's job, triggered by cmd=001 with carryin=1.
- No new request is accepted while busy; requesters keep req_valid high and wait.
- Asynchronous reset in any state aborts the transaction: no response is ever produced for it and the pointer returns to 0.

## Timing
- Accept at edge T (req_valid & req_ready high): rsp_valid rises after edge T+SETTLE. With SETTLE=1 it is visible in the cycle after T+1.
- With rsp_ready held high, the handshake completes at edge T+SETTLE+1. The next accept can occur at edge T+SETTLE+2.
- Peak throughput is one operation per SETTLE+2 cycles.
- req_ready depends combinationally on req_valid and state only, never on rsp_ready.
- A request arriving in the same cycle a response completes is not accepted until the following IDLE cycle.

## Test plan
Bench ALU model: ADD = a+b+cin; SUB = a+~b+cin.
- Req0 ADD 0xFFFFFFFF + 0x00000001, SETTLE=1, rsp_ready=1 -> rsp_valid[0] one cycle after the accept edge, rsp_result=0x00000000, rsp_carry=1, busy low two edges after accept.
- Req1 SUB 5 − 3 -> alu_carryin=1 during SETTLE, rsp_result=0x00000002, rsp_carry=1.
- Req1 SUB 3 − 5 -> rsp_result=0xFFFFFFFE, rsp_carry=0.
- Both req_valid held high for 4 operations -> grants in order 0,1,0,1; each response is routed only to its owner's rsp_valid bit.
- Req0 AND 0xF0F0F0F0 & 0xFF00FF00 with rsp_ready[0]=0 for 5 cycles and rsp_ready[1]=1:
  - rsp_result=0xF000F000 held stable, rsp_carry=0.
  - req1 is not accepted during the wait.
  - The transaction completes only when rsp_ready[0] rises.
- SETTLE=4, reset asserted two cycles after accept -> all outputs return to reset values immediately (asynchronously), no rsp_valid pulse, and after release a pending req1 wins while req0 is idle.
